// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer (divider enabled by MULDIV_DIV_EN)
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [2:0]         op;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opd;
    logic               neg_res;
    logic               special;
    logic [WIDTH-1:0]   spec_val;

    logic               is_div, a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               spec_hit;
    logic [WIDTH-1:0]   spec_next;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, step_next, prod_fix;
    logic [WIDTH-1:0]   mul_val, fix_val;

    assign is_div   = funct3[2];
    assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (is_div && !funct3[0]);
    assign b_signed = (funct3 == 3'b001) || (is_div && !funct3[0]);
    assign a_neg    = a_signed && a[WIDTH-1];
    assign b_neg    = b_signed && b[WIDTH-1];
    assign a_abs    = a_neg ? (~a + 1'b1) : a;
    assign b_abs    = b_neg ? (~b + 1'b1) : b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
    assign mul_val  = (op == 3'b000) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];

`ifdef MULDIV_DIV_EN
    logic               neg_rem;
    logic               div_zero, div_ovf;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quot, rem, q_fix, r_fix;

    assign div_zero  = is_div && (b == '0);
    assign div_ovf   = is_div && !funct3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign spec_hit  = div_zero || div_ovf;
    // Overflow case relies on a being MIN, so passing a through yields MIN.
    assign spec_next = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

    // Partial remainder keeps the shifted-out bit so divisors above 2^(W-1) work.
    assign trial     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};
    assign div_next  = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign step_next = op[2] ? div_next : mul_next;

    assign quot  = acc[WIDTH-1:0];
    assign rem   = acc[2*WIDTH-1:WIDTH];
    assign q_fix = neg_res ? (~quot + 1'b1) : quot;
    assign r_fix = neg_rem ? (~rem + 1'b1) : rem;
    assign fix_val = special ? spec_val : (op[2] ? (op[1] ? r_fix : q_fix) : mul_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_rem <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_rem <= a_neg;
        end
    end
`else
    assign spec_hit  = is_div;
    assign spec_next = '0;
    assign step_next = mul_next;
    assign fix_val   = special ? spec_val : mul_val;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op       <= '0;
            cnt      <= '0;
            acc      <= '0;
            opd      <= '0;
            neg_res  <= 1'b0;
            special  <= 1'b0;
            spec_val <= '0;
            result   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op       <= funct3;
                        cnt      <= CW'(WIDTH - 1);
                        acc      <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
                        opd      <= is_div ? b_abs : a_abs;
                        neg_res  <= a_neg ^ b_neg;
                        special  <= spec_hit;
                        spec_val <= spec_next;
                        state    <= spec_hit ? S_FIX : S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        result <= fix_val;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN) || (state == S_FIX);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq (expectations follow MULDIV_DIV_EN)
module tb_muldiv_seq;
    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [2:0]   funct3;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        int           e0;
        int           lat;
        int           tag;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] last_res;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] dres(input logic [W-1:0] r);
        return DIV_ON ? r : '0;
    endfunction

    function automatic int dlat(input int l);
        return DIV_ON ? l : 2;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with result %h, expected no done", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk($sformatf("result_op%0d", e.tag), result, e.res);
                chk($sformatf("latency_op%0d", e.tag), W'(cyc - e.e0 + 1), W'(e.lat));
            end
        end
    end

    task automatic go(input int tag, input logic [2:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] er, input int el, input logic fl);
        int bcnt;
        int n;
        @(negedge clk);
        funct3 = f; a = av; b = bv; start = 1'b1; flush = fl;
        sb.push_back('{er, cyc + 1, el, tag});
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        funct3 = 3'($urandom); a = $urandom; b = $urandom;
        bcnt = busy ? 1 : 0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            if (busy) bcnt++;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_op%0d: got no done in 200 cycles, expected done", tag);
            sb.delete();
        end
        chk($sformatf("busy_cycles_op%0d", tag), W'(bcnt), W'(el - 1));
        last_res = er;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; a = '0; b = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        chk("reset_result", result, '0);
        reset = 1'b0;

        go(1,  3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 1'b0);
        go(2,  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
        go(3,  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        go(4,  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        go(5,  3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 34, 1'b0);
        go(6,  3'b000, 32'h12345678, 32'd0,        32'h00000000, 34, 1'b0);
        go(7,  3'b100, 32'hFFFFFFF9, 32'd2,        dres(32'hFFFFFFFD), dlat(34), 1'b0);
        go(8,  3'b110, 32'hFFFFFFF9, 32'd2,        dres(32'hFFFFFFFF), dlat(34), 1'b0);
        go(9,  3'b111, 32'd100,      32'd7,        dres(32'd2),        dlat(34), 1'b0);
        go(10, 3'b101, 32'd5,        32'd0,        dres(32'hFFFFFFFF), 2, 1'b0);
        go(11, 3'b100, 32'h80000000, 32'hFFFFFFFF, dres(32'h80000000), 2, 1'b0);
        go(12, 3'b110, 32'h80000000, 32'hFFFFFFFF, dres(32'h00000000), 2, 1'b0);
        go(13, 3'b111, 32'd7,        32'd0,        dres(32'd7),        2, 1'b0);
        go(14, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b1);

        // start held through FIX and DONE must yield a single done
        @(negedge clk);
        funct3 = 3'b101; a = 32'd5; b = 32'd0; start = 1'b1;
        sb.push_back('{dres(32'hFFFFFFFF), cyc + 1, 2, 15});
        repeat (3) @(negedge clk);
        start = 1'b0;
        last_res = dres(32'hFFFFFFFF);
        repeat (40) @(negedge clk);
        chk("held_start_queue_left", W'(sb.size()), '0);

        // flush mid-multiply, with an ignored second start at cycle 5
        @(negedge clk);
        funct3 = 3'b000; a = 32'd5; b = 32'd6; start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 5) begin start = 1'b1; funct3 = 3'b011; a = 32'd1; b = 32'd1; end
            if (i == 10) begin
                flush = 1'b1;
                chk("flush_busy_before", W'(busy), 32'd1);
            end
            if (i == 11) begin
                flush = 1'b0;
                chk("flush_busy_after", W'(busy), '0);
            end
        end
        repeat (40) @(negedge clk);
        chk("flush_result_kept", result, last_res);
        chk("flush_busy_idle", W'(busy), '0);

        // reset mid-divide
        @(negedge clk);
        funct3 = 3'b100; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        if (!DIV_ON) sb.push_back('{32'h0, cyc + 1, 2, 16});
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 20) reset = 1'b1;
            if (i == 21) begin
                chk("midreset_busy", W'(busy), '0);
                chk("midreset_done", W'(done), '0);
                chk("midreset_result", result, '0);
                reset = 1'b0;
            end
        end

        go(17, 3'b101, 32'd9, 32'd3, dres(32'd3), dlat(34), 1'b0);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", W'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer. It sits beside the single-cycle integer ALU and executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Uses a radix-2 shift-add multiply and a restoring divide, one bit per cycle.
- The core pipeline raises start and then stalls on busy until done.

Parameters:
- WIDTH, 32, operand/result width; must be even, ≥ 8.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request; sampled only in IDLE.
- funct3, input, 3, op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a, input, WIDTH, rs1 operand (multiplicand/dividend).
- b, input, WIDTH, rs2 operand (multiplier/divisor).
- flush, input, 1, abort the in-flight op; no done is produced.
- busy, output, 1, high in RUN and FIX.
- done, output, 1, one-cycle pulse; result is valid in that cycle.
- result, output, WIDTH, final value; held until the next accepted start or reset.

Behaviour:
- Reset and interface decision: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset takes priority over flush and start, including mid-operation.
- States: IDLE, RUN, FIX, DONE.
  - IDLE: start=1 latches funct3, a, b, and the sign flags.
    - Signedness: a is signed for MULH, MULHSU, DIV, REM; b is signed for MULH, DIV, REM.
    - Latched operands are made absolute; result-sign flags are recorded.
    - Normal case → RUN with counter=WIDTH-1. Special case → FIX directly.
  - RUN: one iteration per cycle.
    - Multiply: 2*WIDTH accumulator; if multiplier LSB=1, add multiplicand into the upper half; then shift right 1.
    - Divide: shift {rem,quot} left 1; trial-subtract the divisor from rem; if non-negative, keep the difference and set the quotient LSB.
    - Counter decrements; at counter==0 → FIX. RUN lasts exactly WIDTH cycles.
  - FIX: one cycle. Apply sign correction (two's-complement negate where the sign flag is set) and select the output slice:
    - MUL: low WIDTH bits of the product.
    - MULH*: high WIDTH bits of the product.
    - DIV*: quotient, negated if the operand signs differ.
    - REM*: remainder, takes the dividend's sign.
    - Register result → DONE.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Latency (start sampled at edge E0):
  - Normal ops: done high after edge E(WIDTH+2), i.e. 34 cycles for WIDTH=32.
  - Special cases: done high after E2.
- Special cases, detected in IDLE:
  - DIV/DIVU with b=0: quotient = all ones.
  - REM/REMU with b=0: result = a.
  - DIV with a=MIN and b=-1: result = MIN.
  - REM with a=MIN and b=-1: result = 0.
- Handshake and boundary rules:
  - start while busy=1 or in DONE is ignored; no queuing.
  - start in the same cycle as done is ignored, because the FSM is in DONE.
  - The caller must hold funct3/a/b only in the start cycle.
  - flush in RUN or FIX → IDLE next cycle: busy=0, done stays 0, result unchanged. flush in IDLE or DONE has no effect; DONE still pulses.
  - Simultaneous flush and start in IDLE: start is accepted, since flush is a no-op in IDLE.
  - MUL products are computed as full 2*WIDTH magnitude; the negation in FIX spans all 2*WIDTH bits before slicing.
  - funct3 values are all defined, so there is no illegal encoding.

Optional Feature:
- MULDIV_DIV_EN
  - Defined: full divide/remainder support as above.
  - Undefined: divider datapath and special-case logic are omitted. funct3[2]=1 ops skip RUN, go through FIX with result=0, and pulse done after E2. Multiply behaviour is unchanged.

Test Plan:
- MUL, a=7, b=0xFFFFFFFD (-3) → done at cycle 34, result=0xFFFFFFEB; busy high cycles 1–33.
- MULH, a=b=0x80000000 → result=0x40000000. MULHU, a=b=0xFFFFFFFF → result=0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=2 → result=0xFFFFFFFF.
- DIV, a=0xFFFFFFF9 (-7), b=2 → result=0xFFFFFFFD. REM same operands → result=0xFFFFFFFF. REMU, a=100, b=7 → result=2.
- DIVU, a=5, b=0 → result=0xFFFFFFFF, done at cycle 2. DIV, a=0x80000000, b=0xFFFFFFFF → result=0x80000000, done at cycle 2.
- MUL started, flush at cycle 10 → busy=0 at cycle 11, no done ever, result keeps its prior value. A second start pulse at cycle 5 of a different op is ignored.
- Reset asserted at cycle 20 of a DIV → all outputs 0 next edge. Then a fresh DIVU, a=9, b=3 → result=3 at cycle 34.
